seq_array_multiplier: RTL
=========================

# seq_array_multiplier

Parametrised, iterative shift-and-add multiplier with valid/ready handshakes on both sides. It replaces the fixed 4x4 combinational array multiplier with a WIDTH x WIDTH unit that retires one partial product per clock. It sits between the operand source (pins or register file) and the result sink. An optional two's-complement mode is available.

## Interface
- `WIDTH`, default 8: operand width in bits; legal range 2..32. Product width is 2*WIDTH.
- `clk`  input  1  clock; all state updates on the rising edge.
- `rst_n`  input  1  asynchronous, active-low reset.
- `in_valid`  input  1  operands `a`, `b` and `signed_mode` are valid.
- `in_ready`  output  1  block can accept operands; high only in IDLE.
- `a`  input  WIDTH  multiplicand.
- `b`  input  WIDTH  multiplier.
- `signed_mode`  input  1  treat `a`/`b` as two's complement; sampled at accept.
- `out_valid`  output  1  `product` is valid.
- `out_ready`  input  1  sink accepts `product`.
- `product`  output  2*WIDTH  result.
- `busy`  output  1  high in RUN or DONE.

## Operation
- States:
  - IDLE: `in_ready`=1.
  - RUN: iterate.
  - DONE: `out_valid`=1.
- Accept:
  - An accept occurs on an edge where `in_valid` and `in_ready` are both high.
  - On accept, latch magnitude of `a`, magnitude of `b` and the negate flag (`a` sign XOR `b` sign, signed mode only). Clear the accumulator and the step counter. Go to RUN.
- RUN step k (k = 0..WIDTH-1):
  - If bit k of the latched `b` is 1, add latched `a` << k to the 2*WIDTH accumulator. No overflow is possible.
  - Increment the counter.
  - After step WIDTH-1, go to DONE. On that same edge, `product` = accumulator, or its two's-complement negation if the negate flag is set.
- DONE:
  - `product` and `out_valid` are held stable until an edge with `out_ready`=1.
  - On that edge, go to IDLE and drop `out_valid`. `product` keeps its last value.
- No overlap: a new accept is possible only from IDLE, so there is one operation in flight at most.
- `in_valid` seen during RUN or DONE is ignored; there is no queuing.
- Magnitude rules:
  - Unsigned mode: magnitude = operand.
  - Signed mode: magnitude = |operand| as a WIDTH-bit unsigned value. -2^(WIDTH-1) maps to 2^(WIDTH-1) with no saturation.
  - Full signed range is exact, e.g. (-2^(W-1))^2 = 2^(2W-2).
- Zero operands still take the full WIDTH RUN cycles; there is no early termination.

## Timing
- Reset values, applied asynchronously while `rst_n`=0:
  - State IDLE.
  - `in_ready`=1 once reset is released; it is forced to 0 while `rst_n`=0.
  - `out_valid`=0, `busy`=0, `product`=0, counter=0, accumulator=0.
- Latency: `out_valid` rises exactly WIDTH rising edges after the accept edge.
- Throughput: one result per WIDTH+2 cycles at best (accept, WIDTH RUN cycles, the DONE/ready cycle).
- `in_ready` falls on the accept edge. It rises again on the edge that consumes the result.
- `out_ready` held high before DONE: the result is consumed on the first DONE edge, so `out_valid` is high for exactly one cycle.
- Reset mid-RUN or mid-DONE: the operation is abandoned and no result is produced. The first accept after release behaves as from cold reset.
- All outputs are registered; there are no combinational paths from inputs to outputs.

## Configuration
- Macro: `SEQ_MULT_SIGNED_EN`.
- Defined:
  - `signed_mode` is honoured as in Operation.
  - Sign logic adds one 2*WIDTH negator and two WIDTH absolute-value units.
- Undefined:
  - `signed_mode` is ignored; all operations are unsigned.
  - No sign logic is synthesised.
  - The port remains present and is tied into an unused-signal sink.

## Test plan
- WIDTH=4, unsigned:
  - All 256 (a,b) pairs, `out_ready`=1.
  - Expect `product` = a*b, e.g. 15*15 -> 0xE1 and 13*11 -> 0x8F.
  - Expect `out_valid` exactly 4 edges after each accept.
- WIDTH=8, unsigned: 255*255 -> 0xFE01; 0*200 -> 0x0000 after the full 8 RUN cycles; 1*1 -> 0x0001.
- WIDTH=8, `SEQ_MULT_SIGNED_EN` defined, `signed_mode`=1: -128*-128 -> 0x4000; -3*5 -> 0xFFF1; 127*-128 -> 0xC080. Repeat with the macro undefined: 0xFD*0x05 -> 0x04F1 (unsigned).
- Backpressure:
  - Hold `out_ready`=0 for 10 cycles in DONE: `product` stable, `in_ready`=0, `busy`=1.
  - Pulse `out_ready`: next cycle `out_valid`=0 and `in_ready`=1.
  - `in_valid` pulsed with 9*9 during RUN of 7*7: only 0x0031 is produced.
- Reset:
  - Assert `rst_n`=0 at RUN step 3 of 200*100: outputs go to reset values immediately, with no `out_valid`.
  - After release, accept 6*7 -> 0x002A after 8 edges.

Source files
------------

// File: rtl/seq_array_multiplier.sv
// seq_array_multiplier
//   Iterative shift-and-add multiplier. It retires one partial product per
//   clock and has valid/ready handshakes on the operand and result sides.
//   Only one operation is in flight at a time.
//
//   Optional feature macro: SEQ_MULT_SIGNED_EN
//     defined   -> signed_mode selects two's-complement operands
//     undefined -> always unsigned; signed_mode is accepted but ignored
//
// Ports
//   clk         in   rising-edge clock
//   rst_n       in   asynchronous active-low reset
//   in_valid    in   a / b / signed_mode are valid
//   in_ready    out  operands can be accepted (IDLE only, 0 during reset)
//   a           in   WIDTH-bit multiplicand
//   b           in   WIDTH-bit multiplier
//   signed_mode in   two's-complement operands, sampled at accept
//   out_valid   out  product is valid
//   out_ready   in   sink accepts product
//   product     out  2*WIDTH-bit result, holds last value after hand-off
//   busy        out  operation in RUN or DONE

module seq_array_multiplier #(
    parameter int unsigned WIDTH = 8
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [WIDTH-1:0]     a,
    input  logic [WIDTH-1:0]     b,
    input  logic                 signed_mode,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [2*WIDTH-1:0]   product,
    output logic                 busy
);

    localparam int unsigned   CW   = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_RUN,
        S_DONE
    } state_t;

    state_t               r_state;
    state_t               w_next_state;

    logic                 r_in_ready;
    logic                 r_out_valid;
    logic                 r_busy;
    logic [2*WIDTH-1:0]   r_product;
    logic [2*WIDTH-1:0]   r_acc;
    logic [2*WIDTH-1:0]   r_a_sh;   // latched |a|, shifted left once per step
    logic [WIDTH-1:0]     r_b_sh;   // latched |b|, bit 0 is the current step's bit
    logic [CW-1:0]        r_cnt;

    logic                 w_accept;
    logic                 w_last;
    logic [WIDTH-1:0]     w_a_mag;
    logic [WIDTH-1:0]     w_b_mag;
    logic [2*WIDTH-1:0]   w_acc_next;
    logic [2*WIDTH-1:0]   w_result;

    assign w_accept   = (r_state == S_IDLE) && r_in_ready && in_valid;
    assign w_last     = (r_cnt == LAST);
    assign w_acc_next = r_acc + (r_b_sh[0] ? r_a_sh : '0);

`ifdef SEQ_MULT_SIGNED_EN
    logic w_a_neg;
    logic w_b_neg;
    logic r_neg;

    assign w_a_neg = signed_mode & a[WIDTH-1];
    assign w_b_neg = signed_mode & b[WIDTH-1];
    // -(-2^(W-1)) wraps to 2^(W-1), which is the correct unsigned magnitude.
    assign w_a_mag = w_a_neg ? -a : a;
    assign w_b_mag = w_b_neg ? -b : b;
    assign w_result = r_neg ? -w_acc_next : w_acc_next;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_neg <= 1'b0;
        end else if (w_accept) begin
            r_neg <= w_a_neg ^ w_b_neg;
        end
    end
`else
    logic w_unused;

    assign w_unused = signed_mode;
    assign w_a_mag  = a;
    assign w_b_mag  = b;
    assign w_result = w_acc_next;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    always_comb begin
        w_next_state = r_state;
        unique case (r_state)
            S_IDLE: if (w_accept)  w_next_state = S_RUN;
            S_RUN:  if (w_last)    w_next_state = S_DONE;
            S_DONE: if (out_ready) w_next_state = S_IDLE;
            default:               w_next_state = S_IDLE;
        endcase
    end

    // Status outputs are registered from the next state so that they change
    // on the same edge as the state itself, with no input-to-output path.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_in_ready  <= 1'b0;
            r_out_valid <= 1'b0;
            r_busy      <= 1'b0;
            r_product   <= '0;
            r_acc       <= '0;
            r_a_sh      <= '0;
            r_b_sh      <= '0;
            r_cnt       <= '0;
        end else begin
            r_in_ready  <= (w_next_state == S_IDLE);
            r_out_valid <= (w_next_state == S_DONE);
            r_busy      <= (w_next_state != S_IDLE);
            unique case (r_state)
                S_IDLE: begin
                    if (w_accept) begin
                        r_a_sh <= {{WIDTH{1'b0}}, w_a_mag};
                        r_b_sh <= w_b_mag;
                        r_acc  <= '0;
                        r_cnt  <= '0;
                    end
                end
                S_RUN: begin
                    r_acc  <= w_acc_next;
                    r_a_sh <= r_a_sh << 1;
                    r_b_sh <= r_b_sh >> 1;
                    r_cnt  <= r_cnt + CW'(1);
                    if (w_last) begin
                        r_product <= w_result;
                    end
                end
                default: begin
                end
            endcase
        end
    end

    assign in_ready  = r_in_ready;
    assign out_valid = r_out_valid;
    assign busy      = r_busy;
    assign product   = r_product;

endmodule
